// File: rtl/sc_muladd_mod_l_if.sv
// Host-side handshake for sc_muladd_mod_l: start pulse, operands, busy/done and result.
// Optional build macro of the attached block: SC_MULADD_ZERO_SKIP_EN.
interface sc_muladd_mod_l_if #(
  parameter int unsigned OP_W = 253
) ();
  logic            iEn;
  logic [OP_W-1:0] iA;
  logic [OP_W-1:0] iB;
  logic [OP_W-1:0] iC;
  logic            oBusy;
  logic            oDone;
  logic [OP_W-1:0] oResult;

  // Host drives operands and start, observes status and result.
  modport master (
    output iEn, iA, iB, iC,
    input  oBusy, oDone, oResult
  );

  // The multiply-add block consumes operands and produces status and result.
  modport slave (
    input  iEn, iA, iB, iC,
    output oBusy, oDone, oResult
  );
endinterface

// File: rtl/sc_muladd_mod_l.sv
// Ed25519 scalar stage: S = (a*b + c) mod L. Forms the 512-bit product-sum, hands it to
// barrett_reduce, and lends the shared 256x256 multiplier port to the reducer meanwhile.
// Build macro SC_MULADD_ZERO_SKIP_EN: a zero multiplicand/multiplier bypasses the multiply.
module sc_muladd_mod_l #(
  parameter int unsigned OP_W  = 253,
  parameter int unsigned MUL_W = 256
) (
  input  logic                 iClk,
  input  logic                 iRst,
  sc_muladd_mod_l_if.slave     bus,
  // barrett_reduce side
  output logic                 oRedEn,
  output logic [2*MUL_W-1:0]   oRedIn,
  input  logic                 iRedDone,
  input  logic [OP_W-1:0]      iRedResult,
  input  logic                 iRedMulStart,
  input  logic [MUL_W-1:0]     iRedMul_D0,
  input  logic [MUL_W-1:0]     iRedMul_D1,
  output logic                 oRedMulDone,
  output logic [2*MUL_W-1:0]   oRedMul_Q,
  // shared multiplier side
  output logic                 oMulStart,
  output logic [MUL_W-1:0]     oMul_D0,
  output logic [MUL_W-1:0]     oMul_D1,
  input  logic                 iMulDone,
  input  logic [2*MUL_W-1:0]   iMul_Q
);

  localparam int unsigned SumW    = 2 * MUL_W;
  localparam int unsigned OpPadW  = MUL_W - OP_W;
  localparam int unsigned SumPadW = SumW - OP_W;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StMul      = 3'd1,
    StAdd      = 3'd2,
    StRedStart = 3'd3,
    StRedWait  = 3'd4,
    StDone     = 3'd5
  } state_e;

  state_e          state_q;
  logic [OP_W-1:0] a_q, b_q, c_q;
  logic [SumW-1:0] sum_q;
  logic [OP_W-1:0] result_q;
  logic            mul_start_q;
  logic            done_q;
  logic            red_phase;

  // Control FSM with registered pulses; the sum register doubles as the reducer input.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      sum_q       <= '0;
      result_q    <= '0;
      mul_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.iEn) begin
            a_q <= bus.iA;
            b_q <= bus.iB;
            c_q <= bus.iC;
`ifdef SC_MULADD_ZERO_SKIP_EN
            if ((bus.iA == '0) || (bus.iB == '0)) begin
              // Product is zero: the sum is just c, no multiplier traffic.
              sum_q   <= {{SumPadW{1'b0}}, bus.iC};
              state_q <= StRedStart;
            end else begin
              mul_start_q <= 1'b1;
              state_q     <= StMul;
            end
`else
            mul_start_q <= 1'b1;
            state_q     <= StMul;
`endif
          end
        end
        StMul: begin
          if (iMulDone) begin
            sum_q   <= iMul_Q;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          // a*b + c < 2^507, so the 512-bit add cannot carry out.
          sum_q   <= sum_q + {{SumPadW{1'b0}}, c_q};
          state_q <= StRedStart;
        end
        StRedStart: state_q <= StRedWait;
        StRedWait: begin
          if (iRedDone) begin
            result_q <= iRedResult;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign red_phase = (state_q == StRedStart) || (state_q == StRedWait);

  // Multiplier port mux: the reducer owns the port only while a reduction is in flight.
  always_comb begin
    oMulStart   = mul_start_q;
    oMul_D0     = {{OpPadW{1'b0}}, a_q};
    oMul_D1     = {{OpPadW{1'b0}}, b_q};
    oRedMulDone = 1'b0;
    if (red_phase) begin
      oMulStart   = iRedMulStart;
      oMul_D0     = iRedMul_D0;
      oMul_D1     = iRedMul_D1;
      oRedMulDone = iMulDone;
    end
  end

  assign oRedEn      = (state_q == StRedStart);
  assign oRedIn      = sum_q;
  assign oRedMul_Q   = iMul_Q;
  assign bus.oBusy   = (state_q != StIdle);
  assign bus.oDone   = done_q;
  assign bus.oResult = result_q;

endmodule
